// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for the shared combinational alu, with a
// four-phase req/done handshake and registered result/flags.

module alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 8,
  parameter int FLAGW = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OPW-1:0]   op_i,
  output logic [WIDTH-1:0] c_o,
  output logic [FLAGW-1:0] flags_o
);
  localparam int MSB = WIDTH - 1;
  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5);
  localparam logic [OPW-1:0] OP_SHR = OPW'(6);

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             ovf;

  // flags: [0] zero, [1] negative, [2] carry/borrow/shift-out, [3] signed overflow, [4] parity
  always_comb begin
    wide  = '0;
    c     = a_i;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      OP_ADD: begin
        wide  = {1'b0, a_i} + {1'b0, b_i};
        c     = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a_i[MSB] == b_i[MSB]) && (c[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        wide  = {1'b0, a_i} - {1'b0, b_i};
        c     = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a_i[MSB] != b_i[MSB]) && (c[MSB] != a_i[MSB]);
      end
      OP_AND: c = a_i & b_i;
      OP_OR:  c = a_i | b_i;
      OP_XOR: c = a_i ^ b_i;
      OP_SHL: begin
        c     = {a_i[MSB-1:0], 1'b0};
        carry = a_i[MSB];
      end
      OP_SHR: begin
        c     = {1'b0, a_i[MSB:1]};
        carry = a_i[0];
      end
      default: c = a_i;
    endcase
    c_o        = c;
    flags_o    = '0;
    flags_o[0] = ~|c;
    flags_o[1] = c[MSB];
    flags_o[2] = carry;
    flags_o[3] = ovf;
    flags_o[4] = ^c;
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; grants on the first edge a req is seen
// EXEC  | operands latched, alu settling; captures result/flags, raises done
// DONE  | holding done until the granted requester drops req
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 8,
  parameter int FLAGW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   op1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic [FLAGW-1:0] flags,
  output logic             grant,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [OPW-1:0]   opc_q;
  logic             gid_q;
  logic             prio_q;
  logic             done0_q;
  logic             done1_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q;
  logic [FLAGW-1:0] flags_q;

  logic             win_d;
  logic             req_gid_d;
  logic [WIDTH-1:0] alu_c;
  logic [FLAGW-1:0] alu_flags;

  // A lone requester wins outright; prio only breaks ties.
  assign win_d     = (req0 && req1) ? prio_q : req1;
  assign req_gid_d = gid_q ? req1 : req0;

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW),
    .FLAGW (FLAGW)
  ) u_alu (
    .a_i     (opa_q),
    .b_i     (opb_q),
    .op_i    (opc_q),
    .c_o     (alu_c),
    .flags_o (alu_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      gid_q    <= 1'b0;
      prio_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            opa_q   <= win_d ? a1 : a0;
            opb_q   <= win_d ? b1 : b0;
            opc_q   <= win_d ? op1 : op0;
            gid_q   <= win_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_c;
          flags_q  <= alu_flags;
          done0_q  <= ~gid_q;
          done1_q  <= gid_q;
          state_q  <= DONE;
        end
        DONE: begin
          if (!req_gid_d) begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            prio_q  <= ~gid_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign grant  = gid_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued when a request
// is raised and popped when the matching done appears.
module tb_alu_arbiter;
  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_AND = 8'd2;
  localparam logic [7:0] OP_OR  = 8'd3;
  localparam logic [7:0] OP_XOR = 8'd4;
  localparam logic [7:0] OP_SHL = 8'd5;
  localparam logic [7:0] OP_SHR = 8'd6;
  localparam logic [7:0] OP_MOV = 8'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic [7:0]  op0, op1;
  logic        done0, done1, grant, busy;
  logic [15:0] result;
  logic [4:0]  flags;

  typedef struct packed {
    logic        id;
    logic [15:0] c;
    logic [4:0]  f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   overlap_seen = 0;

  alu_arbiter #(.WIDTH(16), .OPW(8), .FLAGW(5)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .done0(done0), .done1(done1), .result(result), .flags(flags),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done0 && done1) overlap_seen = 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got no end, required end)");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] op);
    int ua, ub, sa, sbv, s, r;
    logic [15:0] c;
    logic cy, ov;
    exp_t e;
    ua = int'(a); ub = int'(b);
    sa = $signed(a); sbv = $signed(b);
    cy = 0; ov = 0; c = a;
    case (op)
      OP_ADD: begin s = ua + ub; c = s[15:0]; cy = (s > 65535); r = sa + sbv;
                    ov = (r > 32767) || (r < -32768); end
      OP_SUB: begin s = ua - ub; c = s[15:0]; cy = (ua < ub); r = sa - sbv;
                    ov = (r > 32767) || (r < -32768); end
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_XOR: c = a ^ b;
      OP_SHL: begin s = ua * 2; c = s[15:0]; cy = (ua >= 32768); end
      OP_SHR: begin c = 16'(ua / 2); cy = (ua % 2 == 1); end
      default: c = a;
    endcase
    e.id = id; e.c = c;
    e.f = {^c, ov, cy, c[15], (c == 16'h0000)};
    return e;
  endfunction

  task automatic raise(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] op);
    if (id) begin req1 = 1; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = 1; a0 = a; b0 = b; op0 = op; end
    sb.push_back(model(id, a, b, op));
  endtask

  task automatic drop(input logic id);
    if (id) req1 = 0; else req0 = 0;
  endtask

  task automatic wait_done(output logic id, output bit ok);
    ok = 0; id = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 || done1) begin ok = 1; id = done1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done0, done1, result, flags, grant, busy} !== 25'd0)
      begin errors++; $display("FAIL reset_outputs: got %h required 0",
                               {done0, done1, result, flags, grant, busy}); end
    reset = 0;
  endtask

  task automatic test_single_add();
    exp_t e;
    @(negedge clk);
    raise(0, 16'h0003, 16'h0004, OP_ADD);
    @(negedge clk);
    checks++;
    if (busy !== 1 || grant !== 0 || done0 !== 0)
      begin errors++; $display("FAIL add_grant: busy=%b grant=%b done0=%b required 1 0 0",
                               busy, grant, done0); end
    @(negedge clk);
    checks++;
    if (done0 !== 1 || done1 !== 0)
      begin errors++; $display("FAIL add_done: done0=%b done1=%b required 1 0", done0, done1); end
    e = sb.pop_front();
    checks++;
    if (result !== 16'h0007)
      begin errors++; $display("FAIL add_result: got %h required 0007", result); end
    checks++;
    if (flags !== e.f)
      begin errors++; $display("FAIL add_flags: got %b required %b", flags, e.f); end
    drop(0);
    @(negedge clk);
    checks++;
    if (done0 !== 0 || busy !== 0)
      begin errors++; $display("FAIL add_release: done0=%b busy=%b required 0 0", done0, busy); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic id;
    bit ok;
    reset = 1;
    @(negedge clk);
    reset = 0;
    overlap_seen = 0;
    raise(0, 16'h1111, 16'h0101, OP_SUB);
    raise(1, 16'h00F0, 16'h0F00, OP_OR);
    for (int k = 0; k < 2; k++) begin
      wait_done(id, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sim_timeout: got no done required done"); end
      else begin
        e = sb.pop_front();
        checks++;
        if (id !== e.id || grant !== e.id)
          begin errors++; $display("FAIL sim_order: got id %b grant %b required %b", id, grant, e.id); end
        checks++;
        if (result !== e.c || flags !== e.f)
          begin errors++; $display("FAIL sim_result: got %h/%b required %h/%b",
                                   result, flags, e.c, e.f); end
        drop(id);
        @(negedge clk);
        if (k == 0) begin
          @(negedge clk);
          checks++;
          if (busy !== 1 || grant !== 1)
            begin errors++; $display("FAIL sim_no_gap: busy=%b grant=%b required 1 1", busy, grant); end
        end
      end
    end
    checks++;
    if (overlap_seen !== 0)
      begin errors++; $display("FAIL sim_overlap: both done high got 1 required 0"); end
  endtask

  task automatic test_contention();
    exp_t e;
    logic id;
    bit ok;
    int issued, served;
    overlap_seen = 0;
    raise(0, 16'($urandom), 16'($urandom), 8'($urandom_range(0, 7)));
    raise(1, 16'($urandom), 16'($urandom), 8'($urandom_range(0, 7)));
    issued = 2; served = 0;
    while (served < 6) begin
      wait_done(id, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL cont_timeout: got no done required done after %0d ops", served);
        break;
      end
      e = sb.pop_front();
      checks++;
      if (id !== 1'(served % 2) || grant !== 1'(served % 2))
        begin errors++; $display("FAIL cont_grant: op %0d got id %b grant %b required %0d",
                                 served, id, grant, served % 2); end
      checks++;
      if (result !== e.c || flags !== e.f)
        begin errors++; $display("FAIL cont_result: op %0d got %h/%b required %h/%b",
                                 served, result, flags, e.c, e.f); end
      served++;
      drop(id);
      @(negedge clk);
      if (issued < 6) begin
        raise(id, 16'($urandom), 16'($urandom), 8'($urandom_range(0, 7)));
        issued++;
      end
    end
    checks++;
    if (overlap_seen !== 0)
      begin errors++; $display("FAIL cont_overlap: both done high got 1 required 0"); end
  endtask

  task automatic test_operand_change();
    logic id;
    bit ok;
    exp_t e;
    @(negedge clk);
    raise(0, 16'h0010, 16'h0005, OP_ADD);
    @(negedge clk);
    a0 = 16'hFFFF; b0 = 16'hFFFF; op0 = OP_SUB;
    wait_done(id, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL opchg_timeout: got no done required done"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (result !== 16'h0015 || flags !== e.f || id !== 0)
        begin errors++; $display("FAIL opchg_result: got %h/%b id %b required 0015/%b id 0",
                                 result, flags, id, e.f); end
    end
    drop(0);
    @(negedge clk);
  endtask

  task automatic test_early_release();
    exp_t e;
    @(negedge clk);
    raise(1, 16'h0002, 16'h0005, OP_SUB);
    @(negedge clk);
    drop(1);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (done1 !== 1 || done0 !== 0 || result !== e.c || flags !== e.f)
      begin errors++; $display("FAIL early_done: done1=%b done0=%b res %h/%b required 1 0 %h/%b",
                               done1, done0, result, flags, e.c, e.f); end
    @(negedge clk);
    checks++;
    if (done1 !== 0 || busy !== 0)
      begin errors++; $display("FAIL early_release: done1=%b busy=%b required 0 0", done1, busy); end
    @(negedge clk);
    checks++;
    if (busy !== 0)
      begin errors++; $display("FAIL early_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    raise(0, 16'h0009, 16'h0007, OP_XOR);
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if ({done0, done1, result, flags, grant, busy} !== 25'd0)
      begin errors++; $display("FAIL rst_mid_outputs: got %h required 0",
                               {done0, done1, result, flags, grant, busy}); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1 || done0 !== 0)
      begin errors++; $display("FAIL rst_regrant: busy=%b done0=%b required 1 0", busy, done0); end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (done0 !== 1 || result !== 16'h000E || flags !== e.f)
      begin errors++; $display("FAIL rst_result: done0=%b res %h/%b required 1 000e/%b",
                               done0, result, flags, e.f); end
    drop(0);
    @(negedge clk);
  endtask

  task automatic test_opcodes();
    logic [15:0] ta [10] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000, 16'hF0F0,
                             16'h1200, 16'hAAAA, 16'h8001, 16'h0003, 16'h1234};
    logic [15:0] tb [10] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0FF0,
                             16'h0034, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000};
    logic [7:0]  to [10] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_AND,
                             OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV};
    logic id, want;
    bit ok;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      want = 1'(i % 2);
      @(negedge clk);
      raise(want, ta[i], tb[i], to[i]);
      wait_done(id, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL opc_timeout: entry %0d got no done required done", i); end
      else begin
        e = sb.pop_front();
        checks++;
        if (id !== want || result !== e.c || flags !== e.f)
          begin errors++; $display("FAIL opc_result: entry %0d got id %b %h/%b required %b %h/%b",
                                   i, id, result, flags, want, e.c, e.f); end
      end
      drop(want);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_simultaneous();
    test_contention();
    test_operand_change();
    test_early_release();
    test_reset_mid();
    test_opcodes();
    checks++;
    if (sb.size() !== 0)
      begin errors++; $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared combinational `alu`. It accepts operation requests from two independent requesters, each supplying A, B and Opcode. It grants the ALU round-robin and latches the granted operands into registers. It captures C and Flags into registered outputs and completes a four-phase req/done handshake with the winning requester. It sits between the control FSMs (demo front-end, future instruction sequencer) and the single `alu` instance it contains.

## Interface
Parameters:
- WIDTH, 16, operand/result width (must match `alu`)
- OPW, 8, opcode width
- FLAGW, 5, flag vector width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0  in  1  requester 0 operation request, level
- a0  in  WIDTH  requester 0 operand A
- b0  in  WIDTH  requester 0 operand B
- op0  in  OPW  requester 0 opcode
- req1, a1, b1, op1  in  1/WIDTH/WIDTH/OPW  requester 1, same meaning
- done0  out  1  requester 0 result valid, registered
- done1  out  1  requester 1 result valid, registered
- result  out  WIDTH  registered ALU C for the last completed operation
- flags  out  FLAGW  registered ALU Flags for the last completed operation
- grant  out  1  id of the requester currently or last served
- busy  out  1  high whenever state is not IDLE, registered

## Operation
- Internal registers: opA, opB (WIDTH), opC (OPW), gid (1), prio (1, the requester favoured on a tie), state (2 bits).
- `alu` is driven only from opA/opB/opC; requester inputs never reach the ALU directly.
- FSM states: IDLE, EXEC, DONE.
  - IDLE:
    - Neither req high: stay in IDLE.
    - Exactly one req high: grant that requester.
    - Both req high: grant requester `prio`.
    - On grant: latch a/b/op of the winner into opA/opB/opC, set gid and grant to the winner, go to EXEC.
  - EXEC: latch the ALU C into result and Flags into flags. Set done_gid to 1, go to DONE.
  - DONE:
    - Hold done_gid while req_gid is high.
    - On the edge where req_gid is sampled low: clear done_gid, set prio to ~gid, go to IDLE.
- Handshake (four-phase): requester raises req with stable operands. It keeps req high until it sees done, then drops req. Operand changes after the grant edge have no effect.
- req dropped early (during EXEC): the operation still completes. done_gid is high for exactly one cycle, then the FSM returns to IDLE.
- Only one done is ever high at a time. The done line of the non-granted requester stays 0.
- result and flags hold their value until the next EXEC overwrites them. They are meaningful only while done is high.
- Arithmetic, width and flag semantics are exactly those of `alu`. The arbiter adds no truncation or extension.

## Timing
- Reset values: state=IDLE, prio=0, gid=0, opA=opB=0, opC=0, result=0, flags=0, done0=done1=0, grant=0, busy=0.
- Latency: req sampled high at edge N (IDLE) → operands latched at N. Result, flags and done are valid after edge N+1.
- After done is visible, the requester drops req. The FSM returns to IDLE on the first edge that samples req low. The earliest next grant is the following edge.
- Minimum cycle per operation: 3 edges (grant, execute, release), assuming the requester drops req one cycle after done.
- Fairness: with both req continuously asserted (re-raised immediately after each release), grants alternate 0,1,0,1…
- Reset asserted mid-operation (EXEC or DONE):
  - All registers return to their reset values asynchronously and the in-flight operation is discarded.
  - A requester still holding req is re-granted from IDLE on the first edge after reset deasserts.
- busy rises on the grant edge and falls on the release edge.

## Test plan
- Single request, ADD: req0=1, a0=16'h0003, b0=16'h0004, op0=ADD opcode.
  - done0=1 after the 2nd edge, result=16'h0007, flags per `alu`, grant=0.
  - Drop req0 → done0=0 on the next edge, busy=0.
- Simultaneous first requests after reset: req0 and req1 raised in the same cycle.
  - Requester 0 is served first (prio=0), then requester 1 with no gap beyond the release cycle.
  - done0 and done1 are never high together.
- Sustained contention: both reqs re-raised immediately for 6 operations.
  - Grant sequence is 0,1,0,1,0,1.
  - Each result matches the issuing requester's operands.
- Operand change after grant: a0 changed from 16'h0010 to 16'hFFFF one cycle after grant.
  - result reflects 16'h0010.
- Early release: req1 dropped during EXEC.
  - done1 is high for exactly one cycle, then the FSM returns to IDLE.
- Reset mid-EXEC with req0 held high:
  - All outputs go to 0 immediately.
  - After reset deasserts, req0 is re-granted and done0 rises 2 edges later with the correct result.
